vec_store_serializer: RTL

VEC_STORE_SERIALIZER -- requirements
Module: vec_store_serializer

---
 rtl/vec_store_pkg.sv | 16 +
 rtl/beat_fifo.sv | 58 +++++
 rtl/vec_store_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vec_store_pkg.sv
// Shared sizing constants and FSM state encoding for the vector store serializer.
package vec_store_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 150000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/beat_fifo.sv
// Small synchronous FIFO holding whole input beats; a push on a full FIFO
// is taken only when the head is popped on the same edge.
module beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vec_store_serializer.sv
// Accepts multi-lane pixel beats, buffers them and writes one lane per cycle
// to data memory at consecutive word addresses, flagging out-of-range words.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting beats and writing lanes
//   FLUSH | all beats accepted, draining buffered lanes
//   DONE  | one-cycle completion pulse
module vec_store_serializer
  import vec_store_pkg::*;
#(
  parameter int LANES      = vec_store_pkg::LANES,
  parameter int LANE_W     = vec_store_pkg::LANE_W,
  parameter int FIFO_DEPTH = vec_store_pkg::FIFO_DEPTH,
  parameter int MEM_WORDS  = vec_store_pkg::MEM_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [17:0]             num_words,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    mem_we,
  output logic [31:0]             mem_address,
  output logic [31:0]             mem_wd,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int BEAT_W = LANES * LANE_W;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_word_addr;
  logic [17:0]         r_words_left;
  logic [17:0]         r_beats_left;
  logic [LIDX_W-1:0]   r_lane;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wd;
  logic                r_error;

  logic [17:0]         w_beats_total;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_emit;
  logic                w_last_lane;
  logic                w_pop;
  logic                w_in_range;
  logic [BEAT_W-1:0]   w_head;
  logic [LANE_W-1:0]   w_lane_val;

  assign w_beats_total = 18'((19'(num_words) + 19'(LANES - 1)) / 19'(LANES));

  assign in_ready    = (r_state == RUN) && !w_full && (r_beats_left != '0);
  assign w_accept    = in_valid && in_ready;
  assign w_emit      = ((r_state == RUN) || (r_state == FLUSH)) && !w_empty
                       && (r_words_left != '0);
  // the last word of the job ends its beat early, dropping unused lanes
  assign w_last_lane = (r_lane == LIDX_W'(LANES - 1)) || (r_words_left == 18'd1);
  assign w_pop       = w_emit && w_last_lane;
  assign w_lane_val  = w_head[r_lane*LANE_W +: LANE_W];
  assign w_in_range  = (r_word_addr < 32'(MEM_WORDS));

  beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_beat_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (in_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (num_words == '0) ? DONE : RUN;
      RUN:     if (w_accept && (r_beats_left == 18'd1)) w_state_nxt = FLUSH;
      FLUSH:   if (r_words_left == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_addr  <= '0;
      r_words_left <= '0;
      r_beats_left <= '0;
      r_lane       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wd         <= '0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_word_addr  <= base_addr;
        r_words_left <= num_words;
        r_beats_left <= w_beats_total;
        r_lane       <= '0;
        r_error      <= 1'b0;
      end else begin
        if (w_accept) r_beats_left <= r_beats_left - 18'd1;
        if (w_emit) begin
          // out-of-range words keep their slot and address step, but no write
          r_we         <= w_in_range;
          r_addr       <= r_word_addr;
          r_wd         <= 32'(w_lane_val);
          r_word_addr  <= r_word_addr + 32'd1;
          r_words_left <= r_words_left - 18'd1;
          r_lane       <= w_last_lane ? '0 : r_lane + LIDX_W'(1);
          if (!w_in_range) r_error <= 1'b1;
        end
      end
    end
  end

  assign mem_we      = r_we;
  assign mem_address = r_addr;
  assign mem_wd      = r_wd;
  assign busy        = (r_state == RUN) || (r_state == FLUSH);
  assign done        = (r_state == DONE);
  assign error       = r_error;

endmodule
